des_key_sched: RTL and testbench

Sequential DES key-schedule generator. Loads a 64-bit key and emits the 16 48-bit round subkeys, one per valid/ready handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
Feeds the round datapath, where each subkey is XORed with the expanded right half before the S-box bank. It is the decrypt-capable producer side of that subkey interface.

---
 rtl/des_key_sched.sv | 200 ++++++++++++++++++++
 tb/tb_des_key_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched
//  Description : Sequential DES key-schedule generator. Loads a 64-bit key and
//                presents the 16 48-bit round subkeys one per valid/ready
//                handshake, in encrypt order (K1..K16) or decrypt order
//                (K16..K1).
//  Ports       : i_clk, i_rst      clock / synchronous active-high reset
//                i_key[63:0]       DES key, i_key[63] = DES bit 1
//                i_decrypt         order select, sampled on the start edge
//                i_start           start request, honoured only when idle
//                o_busy            schedule in progress
//                o_subkey[47:0]    current subkey, o_subkey[47] = bit 1
//                o_round[3:0]      DES index of o_subkey minus 1
//                o_valid, i_ready  subkey handshake
//                o_par_err         (DES_KS_PARITY_CHECK_EN only) key byte
//                                  with even parity seen at start
//  Options     : `define DES_KS_PARITY_CHECK_EN adds the parity-check output.
//  Revision    : 1.0  initial release
// ============================================================================
module des_key_sched (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_key,
    input  logic        i_decrypt,
    input  logic        i_start,
    output logic        o_busy,
    output logic [47:0] o_subkey,
    output logic [3:0]  o_round,
    output logic        o_valid,
    input  logic        i_ready
`ifdef DES_KS_PARITY_CHECK_EN
    ,
    output logic        o_par_err
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // DES bit numbers (1 = MSB) of the source for each output position.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [55:0] f_pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
        return r;
    endfunction

    // Shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 indexed from 0.
    function automatic logic f_shift_one(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    endfunction

    function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [27:0] creg_q, creg_d;
    logic [27:0] dreg_q, dreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;

    logic [55:0] w_cd0;
    logic        w_start;
    logic        w_xfer;
    logic        w_last;
    logic [3:0]  w_sh_idx;
    logic        w_sh_one;

    assign w_cd0   = f_pc1(i_key);
    assign w_start = (state_q == ST_IDLE) && i_start;
    assign w_xfer  = (state_q == ST_RUN) && i_ready;
    assign w_last  = (cnt_q == 4'd15);

    // Encrypt: next subkey K(cnt+2) uses shift[cnt+2] (0-based cnt+1).
    // Decrypt: presented K(16-cnt); undoing its rotation uses 0-based 15-cnt.
    assign w_sh_idx = mode_q ? ~cnt_q : (cnt_q + 4'd1);
    assign w_sh_one = f_shift_one(w_sh_idx);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start)          state_d = ST_RUN;
            ST_RUN:  if (w_xfer && w_last) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        o_busy  = 1'b0;
        o_valid = 1'b0;
        if (state_q == ST_RUN) begin
            o_busy  = 1'b1;
            o_valid = 1'b1;
        end
    end

    // ---------------- C/D datapath ----------------
    // C/D always hold the halves of the presented subkey, so the output is a
    // pure permutation of registers and naturally holds after completion.
    always_comb begin
        creg_d = creg_q;
        dreg_d = dreg_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (w_start) begin
            mode_d = i_decrypt;
            cnt_d  = 4'd0;
            if (i_decrypt) begin
                // Total rotation over 16 rounds is 28, so C16/D16 = C0/D0.
                creg_d = w_cd0[55:28];
                dreg_d = w_cd0[27:0];
            end else begin
                creg_d = f_rotl(w_cd0[55:28], 1'b1);
                dreg_d = f_rotl(w_cd0[27:0], 1'b1);
            end
        end else if (w_xfer && !w_last) begin
            cnt_d = cnt_q + 4'd1;
            if (mode_q) begin
                creg_d = f_rotr(creg_q, w_sh_one);
                dreg_d = f_rotr(dreg_q, w_sh_one);
            end else begin
                creg_d = f_rotl(creg_q, w_sh_one);
                dreg_d = f_rotl(dreg_q, w_sh_one);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            creg_q <= '0;
            dreg_q <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            creg_q <= creg_d;
            dreg_q <= dreg_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign o_subkey = f_pc2({creg_q, dreg_q});
    assign o_round  = mode_q ? ~cnt_q : cnt_q;

`ifdef DES_KS_PARITY_CHECK_EN
    logic [7:0] w_byte_even;
    logic       par_err_q;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign w_byte_even[b] = ~^i_key[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)        par_err_q <= 1'b0;
        else if (w_start) par_err_q <= |w_byte_even;
    end

    assign o_par_err = par_err_q;
`else
    // Parity bits are dropped by PC-1 and have no other consumer here.
    logic w_unused_par;
    assign w_unused_par = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                            i_key[24], i_key[16], i_key[8],  i_key[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_key_sched
//  Description : Scoreboard bench for des_key_sched. Stimulus pushes the
//                expected subkey stream; a negedge monitor pops and compares
//                on every handshake and checks hold-stability under
//                backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_des_key_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_start, i_decrypt, i_ready;
    logic [63:0] i_key;
    logic        o_busy, o_valid;
    logic [47:0] o_subkey;
    logic [3:0]  o_round;
`ifdef DES_KS_PARITY_CHECK_EN
    logic        o_par_err;
`endif

    des_key_sched dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_key     (i_key),
        .i_decrypt (i_decrypt),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_subkey  (o_subkey),
        .o_round   (o_round),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
`ifdef DES_KS_PARITY_CHECK_EN
        ,
        .o_par_err (o_par_err)
`endif
    );

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    // Subkeys K1..K16 of the classic worked example for KEY.
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] key;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfer_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic dec);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            int   k;
            k     = dec ? 15 - i : i;
            e.rnd = 4'(k);
            e.key = KS[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input bit rnd);
        int cyc;
        cyc = 0;
        while (o_busy === 1'b1 && cyc < 500) begin
            if (rnd) i_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        i_ready = 1'b1;
        chk("run_completes", 64'(o_busy), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        hold_pend = 1'b0;
    logic [47:0] hold_key;
    logic [3:0]  hold_rnd;

    always @(negedge clk) begin
        if (i_rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && o_valid) begin
                chk("hold_subkey", 64'(o_subkey), 64'(hold_key));
                chk("hold_round",  64'(o_round),  64'(hold_rnd));
            end
            hold_pend = 1'b0;
            if (o_valid && !i_ready) begin
                hold_pend = 1'b1;
                hold_key  = o_subkey;
                hold_rnd  = o_round;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: round %0d subkey 0x%0h, expected no transfer",
                             o_round, o_subkey);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("xfer_round",  64'(o_round),  64'(mon_e.rnd));
                    chk("xfer_subkey", 64'(o_subkey), 64'(mon_e.key));
                end
                xfer_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_decrypt = 1'b0;
        i_ready   = 1'b1;
        i_key     = KEY;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",   64'(o_busy),   64'd0);
        chk("reset_valid",  64'(o_valid),  64'd0);
        chk("reset_subkey", 64'(o_subkey), 64'd0);
        chk("reset_round",  64'(o_round),  64'd0);
`ifdef DES_KS_PARITY_CHECK_EN
        chk("reset_par_err", 64'(o_par_err), 64'd0);
`endif
        i_rst = 1'b0;

        // Run 1: encrypt, ready high, stray starts mid-run and on last cycle.
        @(posedge clk); #1;
        i_start = 1'b1; i_decrypt = 1'b0; i_key = KEY;
        xfer_cnt = 0;
        push_run(1'b0);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("enc_first_valid", 64'(o_valid), 64'd1);
        chk("enc_first_busy",  64'(o_busy),  64'd1);
`ifdef DES_KS_PARITY_CHECK_EN
        chk("par_err_good_key", 64'(o_par_err), 64'd0);
`endif
        for (int c = 1; c <= 15; c++) begin
            i_start = (c == 5);
            @(posedge clk); #1;
        end
        chk("enc_last_busy",  64'(o_busy),  64'd1);
        chk("enc_last_round", 64'(o_round), 64'd15);
        // Start on the final-transfer cycle must be ignored, then accepted next.
        i_start = 1'b1; i_decrypt = 1'b1;
        push_run(1'b1);
        @(posedge clk); #1;
        chk("enc_done_busy",  64'(o_busy),   64'd0);
        chk("enc_done_valid", 64'(o_valid),  64'd0);
        chk("enc_done_hold",  64'(o_subkey), 64'(KS[15]));
        chk("enc_xfer_count", 64'(xfer_cnt), 64'd16);
        xfer_cnt = 0;

        // Run 2: decrypt with random backpressure; key/mode scrambled in RUN.
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("dec_first_valid", 64'(o_valid),  64'd1);
        chk("dec_first_round", 64'(o_round),  64'd15);
        i_key     = 64'hFFFF_0000_A5A5_5A5A;
        i_decrypt = 1'b0;
        wait_done(1'b1);
        chk("dec_xfer_count", 64'(xfer_cnt),     64'd16);
        chk("dec_queue_empty", 64'(exp_q.size()), 64'd0);

        // Run 3: reset on the seventh transfer, then a clean restart.
        @(posedge clk); #1;
        i_start = 1'b1; i_decrypt = 1'b0; i_key = KEY;
        xfer_cnt = 0;
        push_run(1'b0);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("mid_rst_valid",  64'(o_valid),  64'd0);
        chk("mid_rst_busy",   64'(o_busy),   64'd0);
        chk("mid_rst_subkey", 64'(o_subkey), 64'd0);
        chk("mid_rst_xfers",  64'(xfer_cnt), 64'd6);
        exp_q.delete();

        @(posedge clk); #1;
        i_start = 1'b1;
        xfer_cnt = 0;
        push_run(1'b0);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("restart_subkey", 64'(o_subkey), 64'(KS[0]));
        wait_done(1'b0);
        chk("restart_xfer_count", 64'(xfer_cnt), 64'd16);

`ifdef DES_KS_PARITY_CHECK_EN
        // Run 4: last key byte 0xF0 has even parity; schedule is unaffected.
        @(posedge clk); #1;
        i_start = 1'b1; i_decrypt = 1'b0; i_key = 64'h133457799BBCDFF0;
        xfer_cnt = 0;
        push_run(1'b0);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("par_err_bad_key", 64'(o_par_err), 64'd1);
        wait_done(1'b1);
        chk("par_err_held",   64'(o_par_err), 64'd1);
        chk("par_xfer_count", 64'(xfer_cnt),  64'd16);
`endif

        repeat (2) @(posedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
